// File: rtl/wb_arb_pkg.sv
// Shared types for the instruction/data Wishbone memory port arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_GNT_INSTR = 2'd1,
    ARB_GNT_DATA  = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_INSTR = 2'b01;
  localparam logic [1:0] GNT_DATA  = 2'b10;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Saturating cycle counter that flags a granted transaction the slave never acknowledged.
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expire_o = 1'b0;
    end else begin : g_on
      localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
      localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);

      logic [CntW-1:0] r_count;

      always_ff @(posedge clk) begin
        if (rst || clear_i) begin
          r_count <= '0;
        end else if (count_en_i && (r_count != CntMax)) begin
          r_count <= r_count + 1'b1;
        end
      end

      // Fires in the cycle the counter reads TIMEOUT_CYCLES-1, i.e. the last allowed wait cycle.
      assign expire_o = count_en_i && (r_count == CntLast);
    end
  endgenerate

endmodule

// File: rtl/wb_mem_port_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic memory port between instruction and data
// masters; each grant is held until ack, abort or watchdog expiry.
module wb_mem_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_cyc_i,
  input  logic                  instr_stb_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic [DATA_WIDTH-1:0] instr_data_o,
  output logic                  instr_ack_o,
  input  logic                  data_cyc_i,
  input  logic                  data_stb_i,
  input  logic                  data_we_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_data_i,
  output logic [DATA_WIDTH-1:0] data_data_o,
  output logic                  data_ack_o,
  output logic                  mem_cyc_o,
  output logic                  mem_stb_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i,
  output logic [1:0]            grant_o,
  output logic                  timeout_o
);

  arb_state_t r_state;
  logic       r_last_data;
  logic [1:0] r_grant;

  logic w_req_instr;
  logic w_req_data;
  logic w_gnt_instr;
  logic w_gnt_data;
  logic w_cur_cyc;
  logic w_timeout;

  assign w_req_instr = instr_cyc_i & instr_stb_i;
  assign w_req_data  = data_cyc_i & data_stb_i;
  assign w_gnt_instr = (r_state == ARB_GNT_INSTR);
  assign w_gnt_data  = (r_state == ARB_GNT_DATA);
  assign w_cur_cyc   = (w_gnt_instr & instr_cyc_i) | (w_gnt_data & data_cyc_i);

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (r_state == ARB_IDLE),
    .count_en_i (w_cur_cyc & ~mem_ack_i),
    .expire_o   (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_last_data <= 1'b1;
      r_grant     <= GNT_NONE;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          // On a tie the master that was not served last wins.
          if (w_req_instr && (!w_req_data || r_last_data)) begin
            r_state <= ARB_GNT_INSTR;
            r_grant <= GNT_INSTR;
          end else if (w_req_data) begin
            r_state <= ARB_GNT_DATA;
            r_grant <= GNT_DATA;
          end
        end
        ARB_GNT_INSTR: begin
          if (!instr_cyc_i || mem_ack_i || w_timeout) begin
            r_state     <= ARB_IDLE;
            r_grant     <= GNT_NONE;
            r_last_data <= 1'b0;
          end
        end
        ARB_GNT_DATA: begin
          if (!data_cyc_i || mem_ack_i || w_timeout) begin
            r_state     <= ARB_IDLE;
            r_grant     <= GNT_NONE;
            r_last_data <= 1'b1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= GNT_NONE;
        end
      endcase
    end
  end

  always_comb begin
    mem_cyc_o = w_cur_cyc;
    mem_stb_o = (w_gnt_instr & instr_cyc_i & instr_stb_i) | (w_gnt_data & data_cyc_i & data_stb_i);
    mem_we_o  = w_gnt_data & data_we_i;
    mem_addr_o = '0;
    if (w_gnt_instr) begin
      mem_addr_o = instr_addr_i;
    end else if (w_gnt_data) begin
      mem_addr_o = data_addr_i;
    end
    mem_data_o = w_gnt_data ? data_data_i : '0;

    // A forced ack carries zero data so a hung read never returns stale bus contents.
    instr_ack_o  = w_gnt_instr & instr_cyc_i & (mem_ack_i | w_timeout);
    data_ack_o   = w_gnt_data & data_cyc_i & (mem_ack_i | w_timeout);
    instr_data_o = w_timeout ? '0 : mem_data_i;
    data_data_o  = w_timeout ? '0 : mem_data_i;
    timeout_o    = w_timeout;
    grant_o      = r_grant;
  end

endmodule

// File: tb/tb_wb_mem_port_arbiter.sv
// Self-checking bench for wb_mem_port_arbiter: directed scenarios plus randomized traffic.
module tb_wb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_cyc_i = 1'b0, instr_stb_i = 1'b0;
  logic [AW-1:0] instr_addr_i = '0;
  logic [DW-1:0] instr_data_o;
  logic          instr_ack_o;
  logic          data_cyc_i = 1'b0, data_stb_i = 1'b0, data_we_i = 1'b0;
  logic [AW-1:0] data_addr_i = '0;
  logic [DW-1:0] data_data_i = '0;
  logic [DW-1:0] data_data_o;
  logic          data_ack_o;
  logic          mem_cyc_o, mem_stb_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [DW-1:0] mem_data_i = '0;
  logic          mem_ack_i = 1'b0;
  logic [1:0]    grant_o;
  logic          timeout_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_mem_port_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_cyc_i  (instr_cyc_i),
    .instr_stb_i  (instr_stb_i),
    .instr_addr_i (instr_addr_i),
    .instr_data_o (instr_data_o),
    .instr_ack_o  (instr_ack_o),
    .data_cyc_i   (data_cyc_i),
    .data_stb_i   (data_stb_i),
    .data_we_i    (data_we_i),
    .data_addr_i  (data_addr_i),
    .data_data_i  (data_data_i),
    .data_data_o  (data_data_o),
    .data_ack_o   (data_ack_o),
    .mem_cyc_o    (mem_cyc_o),
    .mem_stb_o    (mem_stb_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .grant_o      (grant_o),
    .timeout_o    (timeout_o)
  );

  task automatic idle_inputs();
    instr_cyc_i = 1'b0; instr_stb_i = 1'b0;
    data_cyc_i = 1'b0; data_stb_i = 1'b0; data_we_i = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Returns at the negedge of the first cycle with mem_stb_o high, bounded.
  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      ok = mem_stb_o;
    end
  endtask

  // Called at the negedge of grant cycle 1; raises ack in grant cycle d.
  task automatic do_ack(input int d, input logic [DW-1:0] rd);
    repeat (d - 1) @(negedge clk);
    mem_ack_i = 1'b1;
    mem_data_i = rd;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_cyc_i = 1'b1; instr_stb_i = 1'b1; data_cyc_i = 1'b1; data_stb_i = 1'b1;
    data_we_i = 1'b1; mem_ack_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_cyc_o, mem_stb_o, mem_we_o, instr_ack_o, data_ack_o, timeout_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {mem_cyc_o, mem_stb_o, mem_we_o, instr_ack_o, data_ack_o, timeout_o});
    end
    checks++;
    if (grant_o !== 2'b00 || mem_addr_o !== '0) begin
      errors++;
      $display("FAIL reset_grant got %b/%h want 00/0", grant_o, mem_addr_o);
    end
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_instr_read();
    bit ok;
    instr_addr_i = 32'h0000_0010; instr_cyc_i = 1'b1; instr_stb_i = 1'b1;
    wait_grant(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t1_grant_wait got none want stb"); end
    checks++;
    if (grant_o !== 2'b01 || mem_addr_o !== 32'h10 || mem_we_o !== 1'b0) begin
      errors++;
      $display("FAIL t1_port got %b/%h/%b want 01/10/0", grant_o, mem_addr_o, mem_we_o);
    end
    checks++;
    if (instr_ack_o !== 1'b0) begin errors++; $display("FAIL t1_early_ack c1 got 1 want 0"); end
    @(negedge clk);
    checks++;
    if (instr_ack_o !== 1'b0) begin errors++; $display("FAIL t1_early_ack c2 got 1 want 0"); end
    @(negedge clk);
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_0013;
    #1;
    checks++;
    if (instr_ack_o !== 1'b1 || instr_data_o !== 32'h13 || data_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL t1_ack got %b/%h/%b want 1/13/0", instr_ack_o, instr_data_o, data_ack_o);
    end
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    checks++;
    if (instr_ack_o !== 1'b0 || grant_o !== 2'b00 || mem_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL t1_after got %b/%b/%b want 0/00/0", instr_ack_o, grant_o, mem_cyc_o);
    end
  endtask

  task automatic test_tie();
    bit ok;
    do_reset();
    instr_addr_i = 32'h100; data_addr_i = 32'h200;
    instr_cyc_i = 1'b1; instr_stb_i = 1'b1; data_cyc_i = 1'b1; data_stb_i = 1'b1;
    wait_grant(ok);
    checks++;
    if (!ok || grant_o !== 2'b01) begin
      errors++; $display("FAIL t2_first got %b want 01", grant_o);
    end
    do_ack(1, 32'h1111);
    @(posedge clk);
    #1 mem_ack_i = 1'b0; instr_cyc_i = 1'b0; instr_stb_i = 1'b0;
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b00 || mem_cyc_o !== 1'b0) begin
      errors++; $display("FAIL t2_idle_gap got %b/%b want 00/0", grant_o, mem_cyc_o);
    end
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b10 || mem_addr_o !== 32'h200) begin
      errors++; $display("FAIL t2_second got %b/%h want 10/200", grant_o, mem_addr_o);
    end
    do_ack(1, 32'h2222);
    checks++;
    if (data_ack_o !== 1'b1 || data_data_o !== 32'h2222 || instr_ack_o !== 1'b0) begin
      errors++; $display("FAIL t2_data_ack got %b/%h want 1/2222", data_ack_o, data_data_o);
    end
    @(posedge clk);
    #1 mem_ack_i = 1'b0; data_cyc_i = 1'b0; data_stb_i = 1'b0;
    @(posedge clk);
    #1 instr_cyc_i = 1'b1; instr_stb_i = 1'b1; data_cyc_i = 1'b1; data_stb_i = 1'b1;
    wait_grant(ok);
    checks++;
    if (!ok || grant_o !== 2'b01) begin
      errors++; $display("FAIL t2_repeat_tie got %b want 01", grant_o);
    end
    do_ack(1, 32'h3333);
    @(posedge clk);
    #1 idle_inputs();
  endtask

  task automatic test_write();
    bit ok;
    data_addr_i = 32'h0000_1004; data_data_i = 32'hCAFE_F00D; data_we_i = 1'b1;
    data_cyc_i = 1'b1; data_stb_i = 1'b1;
    wait_grant(ok);
    checks++;
    if (!ok || grant_o !== 2'b10 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h1004
        || mem_data_o !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL t3_write got %b/%b/%h/%h want 10/1/1004/cafef00d",
               grant_o, mem_we_o, mem_addr_o, mem_data_o);
    end
    do_ack(2, 32'h0);
    @(posedge clk);
    #1 mem_ack_i = 1'b0; data_cyc_i = 1'b0; data_stb_i = 1'b0;
    instr_addr_i = 32'h40; instr_cyc_i = 1'b1; instr_stb_i = 1'b1;
    wait_grant(ok);
    checks++;
    if (!ok || mem_we_o !== 1'b0 || mem_data_o !== '0 || mem_addr_o !== 32'h40) begin
      errors++;
      $display("FAIL t3_fetch got %b/%h/%h want 0/0/40", mem_we_o, mem_data_o, mem_addr_o);
    end
    do_ack(1, 32'h5);
    @(posedge clk);
    #1 idle_inputs();
  endtask

  task automatic test_timeout();
    bit ok;
    data_addr_i = 32'h300; data_we_i = 1'b0; data_cyc_i = 1'b1; data_stb_i = 1'b1;
    mem_data_i = 32'hDEAD_BEEF;
    wait_grant(ok);
    checks++;
    if (!ok || grant_o !== 2'b10) begin errors++; $display("FAIL t4_grant got %b want 10", grant_o); end
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (data_ack_o !== 1'b0 || timeout_o !== 1'b0) begin
        errors++; $display("FAIL t4_wait c%0d got %b/%b want 0/0", k, data_ack_o, timeout_o);
      end
    end
    @(negedge clk);
    checks++;
    if (data_ack_o !== 1'b1 || data_data_o !== '0 || timeout_o !== 1'b1 || instr_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL t4_expire got %b/%h/%b want 1/0/1", data_ack_o, data_data_o, timeout_o);
    end
    @(posedge clk);
    #1 data_cyc_i = 1'b0; data_stb_i = 1'b0; mem_ack_i = 1'b1;
    @(negedge clk);
    checks++;
    if (data_ack_o !== 1'b0 || instr_ack_o !== 1'b0 || timeout_o !== 1'b0 || grant_o !== 2'b00) begin
      errors++;
      $display("FAIL t4_late_ack got %b/%b/%b/%b want 0/0/0/00",
               data_ack_o, instr_ack_o, timeout_o, grant_o);
    end
    @(posedge clk);
    #1 idle_inputs();
  endtask

  task automatic test_abort();
    bit ok;
    do_reset();
    instr_addr_i = 32'h500; data_addr_i = 32'h600; data_we_i = 1'b0;
    instr_cyc_i = 1'b1; instr_stb_i = 1'b1; data_cyc_i = 1'b1; data_stb_i = 1'b1;
    wait_grant(ok);
    checks++;
    if (!ok || grant_o !== 2'b01) begin errors++; $display("FAIL t5_grant got %b want 01", grant_o); end
    @(posedge clk);
    #1 instr_cyc_i = 1'b0; instr_stb_i = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_cyc_o !== 1'b0 || mem_stb_o !== 1'b0) begin
      errors++; $display("FAIL t5_drop got %b/%b want 0/0", mem_cyc_o, mem_stb_o);
    end
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b00) begin errors++; $display("FAIL t5_idle got %b want 00", grant_o); end
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b10 || mem_addr_o !== 32'h600) begin
      errors++; $display("FAIL t5_data got %b/%h want 10/600", grant_o, mem_addr_o);
    end
    do_ack(1, 32'h77);
    @(posedge clk);
    #1 idle_inputs();
  endtask

  task automatic test_reset_mid();
    bit ok;
    data_addr_i = 32'h700; data_we_i = 1'b1; data_data_i = 32'h1234_5678;
    data_cyc_i = 1'b1; data_stb_i = 1'b1;
    wait_grant(ok);
    checks++;
    if (!ok || grant_o !== 2'b10) begin errors++; $display("FAIL t6_grant got %b want 10", grant_o); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_cyc_o !== 1'b1) begin errors++; $display("FAIL t6_pre_rst got %b want 1", mem_cyc_o); end
    @(posedge clk);
    #1 instr_addr_i = 32'h800; instr_cyc_i = 1'b1; instr_stb_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_cyc_o, mem_stb_o, mem_we_o, instr_ack_o, data_ack_o, timeout_o} !== 6'b0
        || grant_o !== 2'b00 || mem_addr_o !== '0 || mem_data_o !== '0) begin
      errors++;
      $display("FAIL t6_rst_outputs got %b/%b/%h want 000000/00/0",
               {mem_cyc_o, mem_stb_o, mem_we_o, instr_ack_o, data_ack_o, timeout_o},
               grant_o, mem_addr_o);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    wait_grant(ok);
    checks++;
    if (!ok || grant_o !== 2'b01 || mem_addr_o !== 32'h800) begin
      errors++; $display("FAIL t6_post_tie got %b/%h want 01/800", grant_o, mem_addr_o);
    end
    do_ack(1, 32'h9);
    @(posedge clk);
    #1 idle_inputs();
  endtask

  // Reference: each round's pending requests are served one at a time; a tie goes to the
  // master not served last, and every served master sees its own address and slave data.
  task automatic test_random();
    bit ok, pend_i, pend_d, last_data, exp_data;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] dw, rd;
    logic we;
    int d;
    do_reset();
    last_data = 1'b1;
    for (int r = 0; r < 30; r++) begin
      int pat;
      pat = $urandom_range(1, 3);
      ia = $urandom; da = $urandom; dw = $urandom; we = 1'($urandom_range(0, 1));
      pend_i = (pat != 2); pend_d = (pat != 1);
      instr_addr_i = ia; data_addr_i = da; data_data_i = dw; data_we_i = we;
      instr_cyc_i = pend_i; instr_stb_i = pend_i; data_cyc_i = pend_d; data_stb_i = pend_d;
      while (pend_i || pend_d) begin
        exp_data = pend_d && (!pend_i || !last_data);
        wait_grant(ok);
        checks++;
        if (!ok || grant_o !== (exp_data ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rnd%0d_grant got %b want data=%b", r, grant_o, exp_data);
        end
        checks++;
        if (mem_addr_o !== (exp_data ? da : ia) || mem_we_o !== (exp_data & we)
            || mem_data_o !== (exp_data ? dw : '0)) begin
          errors++;
          $display("FAIL rnd%0d_port got %h/%b/%h want %h/%b/%h", r, mem_addr_o, mem_we_o,
                   mem_data_o, exp_data ? da : ia, exp_data & we, exp_data ? dw : '0);
        end
        d = $urandom_range(1, 3);
        rd = $urandom;
        do_ack(d, rd);
        checks++;
        if ({data_ack_o, instr_ack_o} !== (exp_data ? 2'b10 : 2'b01)
            || (exp_data ? data_data_o : instr_data_o) !== rd) begin
          errors++;
          $display("FAIL rnd%0d_ack got %b/%h want data=%b/%h", r, {data_ack_o, instr_ack_o},
                   exp_data ? data_data_o : instr_data_o, exp_data, rd);
        end
        @(posedge clk);
        #1 mem_ack_i = 1'b0;
        if (exp_data) begin
          pend_d = 1'b0; data_cyc_i = 1'b0; data_stb_i = 1'b0;
        end else begin
          pend_i = 1'b0; instr_cyc_i = 1'b0; instr_stb_i = 1'b0;
        end
        last_data = exp_data;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_instr_read();
    test_tie();
    test_write();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit got hang want completion");
    $fatal(1, "time limit");
  end

endmodule
